// File: rtl/p_cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor: one SEG-bit lookahead segment per
// register stage, with optional signed saturation and overflow/carry reporting.
module p_cla_pipe #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_ci,
    input  logic             in_sub,
    input  logic             in_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_co,
    output logic             out_ov
);
    localparam int SEGC = (SEG < 1) ? 1 : SEG;
    localparam int NSEG = WIDTH / SEGC;
    localparam logic [WIDTH-1:0] SMAX = {WIDTH{1'b1}} >> 1;
    localparam logic [WIDTH-1:0] SMIN = ~SMAX;

    if (SEG < 1 || WIDTH < 1 || (WIDTH % SEGC) != 0) begin : g_param_check
        $error("p_cla_pipe: WIDTH must be a positive multiple of SEG, SEG >= 1");
    end

    // Returns {carry out, carry into segment MSB, segment sum}; carries are
    // formed in two-level generate/propagate form rather than rippled.
    function automatic logic [SEGC+1:0] seg_add(input logic [SEGC-1:0] a,
                                                input logic [SEGC-1:0] b,
                                                input logic cin);
        logic [SEGC-1:0] g;
        logic [SEGC-1:0] p;
        logic [SEGC:0]   c;
        logic            term;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int i = 1; i <= SEGC; i++) begin
            term = cin;
            for (int j = 0; j < i; j++) term = term & p[j];
            c[i] = term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int m = j + 1; m < i; m++) term = term & p[m];
                c[i] = c[i] | term;
            end
        end
        return {c[SEGC], c[SEGC-1], p ^ c[SEGC-1:0]};
    endfunction

    // Stage k holds operands, the sum bits finished so far and the carry into
    // segment k. Stage 0 is the input capture, stage NSEG the completed raw sum.
    logic [NSEG:0]    v_q;
    logic [NSEG:0]    c_q;
    logic [NSEG:0]    sat_q;
    logic [WIDTH-1:0] a_q [NSEG+1];
    logic [WIDTH-1:0] b_q [NSEG+1];
    logic [WIDTH-1:0] s_q [NSEG+1];
    logic             ov_q;

    logic [WIDTH-1:0] s_nxt [NSEG+1];
    logic [SEGC+1:0]  seg_r [NSEG+1];
    logic [NSEG:1]    c_nxt;
    logic             ov_nxt;
    logic             en;

    // Handshake: a beat moves when valid & ready are both high at a rising edge.
    // The whole pipe advances together whenever the output register is empty or
    // being drained, so in_ready is that same enable and stalls freeze every stage.
    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    always_comb begin
        for (int k = 0; k <= NSEG; k++) begin
            s_nxt[k] = '0;
            seg_r[k] = '0;
        end
        c_nxt  = '0;
        ov_nxt = 1'b0;
        for (int k = 1; k <= NSEG; k++) begin
            seg_r[k] = seg_add(a_q[k-1][(k-1)*SEGC +: SEGC],
                               b_q[k-1][(k-1)*SEGC +: SEGC], c_q[k-1]);
            s_nxt[k] = s_q[k-1];
            s_nxt[k][(k-1)*SEGC +: SEGC] = seg_r[k][SEGC-1:0];
            c_nxt[k] = seg_r[k][SEGC+1];
        end
        ov_nxt = seg_r[NSEG][SEGC+1] ^ seg_r[NSEG][SEGC];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q       <= '0;
            c_q       <= '0;
            sat_q     <= '0;
            ov_q      <= 1'b0;
            for (int k = 0; k <= NSEG; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            out_valid <= 1'b0;
            out_s     <= '0;
            out_co    <= 1'b0;
            out_ov    <= 1'b0;
        end else if (en) begin
            v_q[0]   <= in_valid;
            a_q[0]   <= in_a;
            b_q[0]   <= in_sub ? ~in_b : in_b;
            c_q[0]   <= in_sub | in_ci;
            sat_q[0] <= in_sat;
            s_q[0]   <= '0;
            for (int k = 1; k <= NSEG; k++) begin
                v_q[k]   <= v_q[k-1];
                a_q[k]   <= a_q[k-1];
                b_q[k]   <= b_q[k-1];
                sat_q[k] <= sat_q[k-1];
                s_q[k]   <= s_nxt[k];
                c_q[k]   <= c_nxt[k];
            end
            ov_q      <= ov_nxt;
            out_valid <= v_q[NSEG];
            out_co    <= c_q[NSEG];
            out_ov    <= ov_q;
            // Signed overflow always leaves the true result on A's side of zero.
            if (sat_q[NSEG] && ov_q)
                out_s <= a_q[NSEG][WIDTH-1] ? SMIN : SMAX;
            else
                out_s <= s_q[NSEG];
        end
    end
endmodule

// File: tb/tb_p_cla_pipe.sv
// Bench for p_cla_pipe: integer-arithmetic reference model with a per-cycle
// compare process, plus directed literal vectors, backpressure and reset cases.
module tb_p_cla_pipe;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, in_ci, in_sub, in_sat;
    logic [W-1:0]  in_a, in_b, out_s;
    logic          out_valid, out_ready, out_co, out_ov;

    logic          v2, rdy2, ci2, sub2, sat2, ov2_valid, oready2, co2, ovf2;
    logic [31:0]   a2, b2, s2;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            n_out = 0;
    logic [17:0]   exp_q[$];
    logic          stall_prev;
    logic [17:0]   held;

    always #5 clk = ~clk;

    p_cla_pipe #(.WIDTH(16), .SEG(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_ci(in_ci), .in_sub(in_sub), .in_sat(in_sat),
        .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s),
        .out_co(out_co), .out_ov(out_ov)
    );

    p_cla_pipe #(.WIDTH(32), .SEG(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2),
        .in_a(a2), .in_b(b2), .in_ci(ci2), .in_sub(sub2), .in_sat(sat2),
        .out_valid(ov2_valid), .out_ready(oready2), .out_s(s2),
        .out_co(co2), .out_ov(ovf2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: true signed result in plain integers, range-checked for overflow.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci, input logic sub, input logic sat);
        int sa, sb, ua, ub, ic, st;
        logic co, ov;
        logic [15:0] s;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = int'({16'h0, a});
        ub = int'({16'h0, b});
        ic = ci ? 1 : 0;
        if (sub) begin
            st = sa - sb;
            co = (ua >= ub);
        end else begin
            st = sa + sb + ic;
            co = (ua + ub + ic) > 65535;
        end
        ov = (st > 32767) || (st < -32768);
        s  = st[15:0];
        if (sat && ov) s = (st > 0) ? 16'h7FFF : 16'h8000;
        return {ov, co, s};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                check("stall_hold", {out_valid, out_ov, out_co, out_s}, {1'b1, held});
            if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
            if (!out_valid) check("idle_in_ready", in_ready, 1);
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) check("unexpected_out", out_valid, 0);
                else check("result", {out_ov, out_co, out_s}, exp_q.pop_front());
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_ci, in_sub, in_sat));
            stall_prev = out_valid && !out_ready;
            held       = {out_ov, out_co, out_s};
        end
    end

    task automatic run_beat(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic ci, input logic sub, input logic sat,
                            input logic [15:0] es, input logic eco, input logic eov);
        int cyc;
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = a; in_b = b; in_ci = ci; in_sub = sub; in_sat = sat;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, "_latency"}, 64'(cyc), 5);
        check({name, "_s"}, out_s, es);
        check({name, "_co"}, out_co, eco);
        check({name, "_ov"}, out_ov, eov);
    endtask

    task automatic pick_random();
        in_a   = 16'($urandom_range(0, 65535));
        in_b   = 16'($urandom_range(0, 65535));
        in_ci  = 1'($urandom_range(0, 1));
        in_sub = 1'($urandom_range(0, 1));
        in_sat = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, guard, cyc, outs_before;
        logic acc;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_ci = 1'b0;
        in_sub = 1'b0; in_sat = 1'b0; out_ready = 1'b0;
        v2 = 1'b0; a2 = '0; b2 = '0; ci2 = 1'b0; sub2 = 1'b0; sat2 = 1'b0; oready2 = 1'b1;
        #1;
        check("reset_valid", out_valid, 0);
        check("reset_s", out_s, 0);
        check("reset_co_ov", {out_co, out_ov}, 0);
        check("reset_in_ready", in_ready, 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run_beat("add_ci",   16'h1234, 16'h0FFF, 1, 0, 0, 16'h2234, 0, 0);
        run_beat("ovf",      16'h7FFF, 16'h0001, 0, 0, 0, 16'h8000, 0, 1);
        run_beat("ovf_sat",  16'h7FFF, 16'h0001, 0, 0, 1, 16'h7FFF, 0, 1);
        run_beat("sub_ci0",  16'h8000, 16'h0001, 0, 1, 0, 16'h7FFF, 1, 1);
        run_beat("sub_ci1",  16'h8000, 16'h0001, 1, 1, 0, 16'h7FFF, 1, 1);
        run_beat("subs_ci0", 16'h8000, 16'h0001, 0, 1, 1, 16'h8000, 1, 1);
        run_beat("subs_ci1", 16'h8000, 16'h0001, 1, 1, 1, 16'h8000, 1, 1);
        run_beat("ripple",   16'hFFFF, 16'h0000, 1, 0, 0, 16'h0000, 1, 0);

        // 32-bit instance: carry rippling through all four 8-bit segments.
        @(posedge clk); #1;
        v2 = 1'b1; a2 = 32'hFFFF_FFFF; b2 = 32'h0; ci2 = 1'b1;
        @(posedge clk); #1;
        v2 = 1'b0;
        cyc = 0;
        while (!ov2_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("w32_latency", 64'(cyc), 5);
        check("w32_s", s2, 0);
        check("w32_co_ov", {co2, ovf2}, 2'b10);

        // Back-to-back random beats with out_ready toggling every cycle.
        outs_before = n_out;
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; pick_random();
        sent = 0; guard = 0;
        while (sent < 8 && guard < 200) begin
            #1 acc = in_ready;
            @(posedge clk); #1;
            guard++;
            out_ready = ~out_ready;
            if (acc) begin
                sent++;
                if (sent < 8) pick_random();
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        while (exp_q.size() > 0 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
            out_ready = ~out_ready;
        end
        check("stream_drained", 64'(exp_q.size()), 0);
        check("stream_count", 64'(n_out - outs_before), 8);

        // Reset with three beats in flight and the first one stalled at the output.
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1;
        in_a = 16'h1111; in_b = 16'h2222; in_ci = 1'b0; in_sub = 1'b0; in_sat = 1'b0;
        @(posedge clk); #1; in_a = 16'h3333;
        @(posedge clk); #1; in_a = 16'h4444;
        @(posedge clk); #1; in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("pre_reset_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_s", out_s, 0);
        check("midrst_co_ov", {out_co, out_ov}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("post_reset_quiet", out_valid, 0);
        end
        run_beat("after_rst", 16'h0001, 16'h0001, 0, 0, 0, 16'h0002, 0, 0);
        repeat (3) @(posedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
